uart_rx_byte: RTL and testbench

Serial-to-parallel UART receiver for the RXD path: 8N1 frames, LSB first, idle-high line. Each received byte is held on a registered output. The upper and lower nibbles feed the two seven-segment decoder instances directly, data_out[7:4] to one and data_out[3:0] to the other. The block also supplies a one-cycle strobe for downstream logic and flags framing errors.

---
 rtl/uart_rx_byte.sv | 156 +++++++++++++++
 tb/tb_uart_rx_byte.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver, LSB first, idle-high line.
// Each correctly framed byte is held on data_out. data_out[7:4] and
// data_out[3:0] drive the two external seven-segment decoders directly.
// data_valid and frame_err are one-cycle strobes. busy is high while a frame
// is in progress.
module uart_rx_byte #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  // Compare points: the start bit is checked at its middle. After that, each
  // full bit period lands on the middle of the next bit.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);

  // A bit period shorter than 4 clocks leaves no room for the mid-bit sample.
  if (CLKS_PER_BIT < 4) begin : g_cfg_check
    $error("uart_rx_byte: CLK_FREQ/BAUD must be at least 4");
  end

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             rx_meta;
  logic             rx_s;
  logic             rx_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_nxt;
  logic [7:0]       shift;
  logic [7:0]       shift_nxt;
  logic [7:0]       data_nxt;
  logic             valid_nxt;
  logic             ferr_nxt;

  // Two-flop synchronizer plus one delay flop for falling-edge detection.
  // The flops are preset high so that reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  // Frame sequencing: compute the next state, counters, shift register and output strobes.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    data_nxt    = data_out;
    valid_nxt   = 1'b0;
    ferr_nxt    = 1'b0;
    case (state)
      IDLE: begin
        // Trigger only on a high-to-low transition. A line stuck low stays idle.
        if (rx_d && !rx_s) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_nxt = '0;
          if (!rx_s) begin
            state_nxt   = DATA;
            bit_idx_nxt = 3'd0;
          end else begin
            // The line went high again before mid-start: treat it as a glitch.
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          shift_nxt   = {rx_s, shift[7:1]};
          cnt_nxt     = '0;
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          if (rx_s) begin
            data_nxt  = shift;
            valid_nxt = 1'b1;
          end else begin
            ferr_nxt = 1'b1;
          end
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State register, counters and registered outputs. Reset aborts any frame silently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      shift      <= 8'h00;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bit_idx    <= bit_idx_nxt;
      shift      <= shift_nxt;
      data_out   <= data_nxt;
      data_valid <= valid_nxt;
      frame_err  <= ferr_nxt;
      busy       <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Testbench for uart_rx_byte with CLK_FREQ=16 and BAUD=1 (16 clocks per bit).
// The bench keeps a scoreboard of frames it has put on the line. Each frame
// predicts the cycle of its strobe and the window in which busy is high.
module tb_uart_rx_byte;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  // A falling rxd is seen by the edge detector 3 clocks later (2 sync + 1 detect).
  localparam int DET  = 3;
  // Stop-bit sample edge: detect, half a start bit, 8 data bits and the stop bit.
  localparam int DONE = DET + HALF + 9 * CPB;

  localparam int K_GOOD   = 0;
  localparam int K_FERR   = 1;
  localparam int K_GLITCH = 2;

  typedef struct {
    int         k;
    int         kind;
    logic [7:0] d;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  bit         chk = 1'b0;
  ev_t        q[$];
  logic [7:0] exp_data = 8'h00;

  int         n_valid = 0;
  int         n_vrise = 0;
  int         n_ferr = 0;
  int         n_busy = 0;
  logic       prev_valid = 1'b0;
  int         vq[$];
  logic [7:0] dq[$];

  uart_rx_byte #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison of all outputs against the frame scoreboard.
  always @(negedge clk) begin
    logic exp_v;
    logic exp_f;
    logic exp_b;
    int   bend;
    if (chk) begin
      exp_v = 1'b0;
      exp_f = 1'b0;
      exp_b = 1'b0;
      foreach (q[i]) begin
        bend = (q[i].kind == K_GLITCH) ? q[i].k + DET + HALF - 1 : q[i].k + DONE - 1;
        if (cyc >= q[i].k + DET && cyc <= bend) exp_b = 1'b1;
        if (q[i].kind != K_GLITCH && cyc == q[i].k + DONE) begin
          if (q[i].kind == K_GOOD) begin
            exp_v    = 1'b1;
            exp_data = q[i].d;
          end else begin
            exp_f = 1'b1;
          end
        end
      end
      while (q.size() > 0 && cyc >= q[0].k + DONE) void'(q.pop_front());
      check("data_out", {24'd0, data_out}, {24'd0, exp_data});
      check("data_valid", {31'd0, data_valid}, {31'd0, exp_v});
      check("frame_err", {31'd0, frame_err}, {31'd0, exp_f});
      check("busy", {31'd0, busy}, {31'd0, exp_b});
    end
  end

  // Observation counters used by the literal end-of-test checks.
  always @(negedge clk) begin
    if (chk) begin
      if (data_valid) begin
        n_valid++;
        vq.push_back(cyc);
        dq.push_back(data_out);
      end
      if (data_valid && !prev_valid) n_vrise++;
      if (frame_err) n_ferr++;
      if (busy) n_busy++;
      prev_valid = data_valid;
    end
  end

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1 rxd = 1'b1;
    end
  endtask

  // One 10-bit frame, 16 clocks per bit. rst_at >= 0 pulses rst_n for one
  // clock at that cycle offset and flushes the scoreboard.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int rst_at);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int c = 0; c < 10 * CPB; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) q.push_back('{cyc, (stop ? K_GOOD : K_FERR), b});
      rxd = bits[c / CPB];
      if (c == rst_at) rst_n = 1'b0;
      if (rst_at >= 0 && c == rst_at + 1) begin
        rst_n = 1'b1;
        q.delete();
        exp_data = 8'h00;
      end
    end
  endtask

  task automatic glitch(input int len);
    for (int c = 0; c < len; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) q.push_back('{cyc, K_GLITCH, 8'h00});
      rxd = 1'b0;
    end
  endtask

  task automatic hold_low(input int len);
    for (int c = 0; c < len; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) q.push_back('{cyc, K_FERR, 8'h00});
      rxd = 1'b0;
    end
  endtask

  initial begin
    int bv;
    int bf;
    int bb;

    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_data_out", {24'd0, data_out}, 32'h0);
    check("reset_valid", {31'd0, data_valid}, 32'h0);
    check("reset_ferr", {31'd0, frame_err}, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'h0);
    chk = 1'b1;
    idle(20);

    // Single good frame.
    bv = n_valid; bf = n_ferr;
    send_frame(8'hA5, 1'b1, -1);
    idle(40);
    check("t1_valid_cycles", n_valid - bv, 1);
    check("t1_valid_pulses", n_vrise, 1);
    check("t1_data", {24'd0, data_out}, 32'hA5);
    check("t1_hi_nibble", {28'd0, data_out[7:4]}, 32'hA);
    check("t1_lo_nibble", {28'd0, data_out[3:0]}, 32'h5);
    check("t1_ferr", n_ferr - bf, 0);
    check("t1_busy_idle", {31'd0, busy}, 32'h0);

    // Short low glitch on an idle line.
    bv = n_valid; bf = n_ferr; bb = n_busy;
    glitch(4);
    idle(60);
    check("glitch_valid", n_valid - bv, 0);
    check("glitch_ferr", n_ferr - bf, 0);
    check("glitch_data", {24'd0, data_out}, 32'hA5);
    check("glitch_busy_le_9", {31'd0, (n_busy - bb) <= 9}, 32'h1);

    // A good frame, then a frame whose stop bit is low.
    bv = n_valid; bf = n_ferr;
    send_frame(8'hA5, 1'b1, -1);
    idle(32);
    send_frame(8'h3C, 1'b0, -1);
    idle(40);
    check("badstop_ferr", n_ferr - bf, 1);
    check("badstop_valid", n_valid - bv, 1);
    check("badstop_data", {24'd0, data_out}, 32'hA5);

    // Back-to-back frames with no idle gap.
    vq.delete(); dq.delete();
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    idle(40);
    check("b2b_count", vq.size(), 2);
    check("b2b_spacing", (vq.size() == 2) ? vq[1] - vq[0] : -1, 160);
    check("b2b_first", (dq.size() > 0) ? {24'd0, dq[0]} : 32'hFFFF, 32'h00);
    check("b2b_second", {24'd0, data_out}, 32'hFF);

    // Reset pulse during the data bits (bit 7 of 0x81, line high).
    bv = n_valid; bf = n_ferr;
    send_frame(8'h81, 1'b1, 8 * CPB + 6);
    check("rst_data", {24'd0, data_out}, 32'h00);
    check("rst_busy", {31'd0, busy}, 32'h0);
    idle(32);
    check("rst_no_valid", n_valid - bv, 0);
    check("rst_no_ferr", n_ferr - bf, 0);
    send_frame(8'h12, 1'b1, -1);
    idle(40);
    check("after_rst_data", {24'd0, data_out}, 32'h12);

    // Break: line low for 40 bit times.
    bv = n_valid; bf = n_ferr;
    hold_low(40 * CPB);
    check("break_ferr", n_ferr - bf, 1);
    check("break_valid", n_valid - bv, 0);
    check("break_data", {24'd0, data_out}, 32'h12);
    idle(48);
    send_frame(8'h55, 1'b1, -1);
    idle(40);
    check("after_break_data", {24'd0, data_out}, 32'h55);
    check("after_break_ferr", n_ferr - bf, 1);

    chk = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
